// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

    // Default instruction-memory word-address width (matches the core PC width).
    localparam int IMEM_AW    = 8;
    // Bytes per instruction word.
    localparam int WORD_BYTES = 4;
    // Width of the byte-within-word counter.
    localparam int BCNT_W     = $clog2(WORD_BYTES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/word_assembler.sv
// Packs a big-endian byte stream into 32-bit words (first byte lands in [31:24]).
// Latency: word complete on the edge accepting its last byte; last is combinational.
// Backpressure: none of its own; the parent decides when a byte is pushed.
module word_assembler
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        push,
    input  logic [7:0]  in_byte,
    output logic [31:0] word,
    output logic        last
);

    logic [BCNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [31:0]       word_q, word_d;

    // Shift the new byte in at the bottom; after four pushes byte 0 sits at the top.
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        if (clr) begin
            byte_cnt_d = '0;
            word_d     = '0;
        end else if (push) begin
            word_d = {word_q[23:0], in_byte};
            if (byte_cnt_q == BCNT_W'(WORD_BYTES - 1)) begin
                byte_cnt_d = '0;
            end else begin
                byte_cnt_d = byte_cnt_q + BCNT_W'(1);
            end
        end
    end

    // Assembly state; cleared asynchronously so a reset drops any partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q <= '0;
            word_q     <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
        end
    end

    assign word = word_q;
    assign last = push && !clr && (byte_cnt_q == BCNT_W'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Streams program bytes into instruction memory, then releases the core from reset.
// Latency: wr_en asserts the cycle after the 4th byte of a word is accepted.
// Backpressure: in_ready only in LOAD; dropped during the one-cycle WRITE.
module imem_loader #(
    parameter int IMEM_AW = mips_pkg::IMEM_AW,
    parameter int LEN_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [LEN_W-1:0]   load_len,
    input  logic               abort,
    input  logic               in_valid,
    input  logic [7:0]         in_byte,
    output logic               in_ready,
    output logic               wr_en,
    output logic [IMEM_AW-1:0] wr_addr,
    output logic [31:0]        wr_data,
    output logic               busy,
    output logic               done,
    output logic               cpu_rst_n
);

    import mips_pkg::*;

    loader_state_t      state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   word_cnt_q, word_cnt_d;
    logic [IMEM_AW-1:0] addr_q, addr_d;

    logic               asm_clr;
    logic               asm_push;
    logic               asm_last;
    logic [31:0]        asm_word;

    // Word count runs at LEN_W for the completion test; the address runs
    // alongside at IMEM_AW so it wraps independently of the length width.
    word_assembler u_asm (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (asm_clr),
        .push    (asm_push),
        .in_byte (in_byte),
        .word    (asm_word),
        .last    (asm_last)
    );

    // Next-state, counter updates and state-decoded outputs; abort wins over everything.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        addr_d     = addr_q;
        asm_clr    = 1'b0;
        asm_push   = 1'b0;
        in_ready   = 1'b0;
        wr_en      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        cpu_rst_n  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    done      = 1'b1;
                    cpu_rst_n = 1'b1;
                end
                if (start) begin
                    len_d      = load_len;
                    word_cnt_d = '0;
                    addr_d     = '0;
                    asm_clr    = 1'b1;
                    state_d    = (load_len == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                asm_push = in_valid;
                // A stalled in_valid simply leaves everything where it is.
                if (asm_last) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                busy       = 1'b1;
                wr_en      = 1'b1;
                word_cnt_d = word_cnt_q + LEN_W'(1);
                addr_d     = addr_q + IMEM_AW'(1);
                state_d    = ((word_cnt_q + LEN_W'(1)) == len_q) ? DONE : LOAD;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Cancel: drop any partial word, suppress a pending write, go idle.
        if (abort) begin
            state_d    = IDLE;
            word_cnt_d = '0;
            addr_d     = '0;
            asm_clr    = 1'b1;
            asm_push   = 1'b0;
            wr_en      = 1'b0;
        end
    end

    // FSM and counter registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            word_cnt_q <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            addr_q     <= addr_d;
        end
    end

    assign wr_addr = addr_q;
    assign wr_data = asm_word;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: vector table plus directed corner sequences.
// Latency: expects each write one cycle after the 4th accepted byte of its word.
// Backpressure: bytes are held until in_ready && in_valid.
module tb_imem_loader;

    localparam int AW = 3;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] load_len = '0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_byte = '0;
    logic          in_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          busy;
    logic          done;
    logic          cpu_rst_n;

    imem_loader #(.IMEM_AW(AW), .LEN_W(LW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .load_len  (load_len),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .cpu_rst_n (cpu_rst_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        int            cyc;
    } wr_t;

    wr_t exp_q[$];
    wr_t obs_q[$];

    // Observed writes, sampled mid-cycle.
    always @(negedge clk) begin
        if (wr_en) obs_q.push_back('{wr_addr, wr_data, cyc});
    end

    int errors = 0;
    int checks = 0;
    logic [7:0] stream [0:63];

    typedef struct {
        int          len;
        bit          use_fixed;
        logic [63:0] fixed;
        logic [15:0] vpat;
        int          vlen;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_start(input int len);
        load_len = LW'(len);
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) stream[i] = 8'($urandom_range(0, 255));
    endtask

    // Present bytes stream[first .. first+count-1]; in_valid follows vpat (LSB first, period vlen).
    task automatic feed(input int first, input int count, input logic [15:0] vpat, input int vlen);
        int idx;
        int t;
        idx = first;
        t   = 0;
        while (idx < first + count && t < 400) begin
            in_valid = vpat[t % vlen];
            in_byte  = stream[idx];
            @(negedge clk);
            if (in_valid && in_ready) begin
                if (idx % 4 == 3) begin
                    exp_q.push_back('{AW'(idx / 4),
                                      {stream[idx-3], stream[idx-2], stream[idx-1], stream[idx]},
                                      cyc + 1});
                end
                idx++;
            end
            t++;
            step();
        end
        in_valid = 1'b0;
        if (idx < first + count) chk("feed_timeout", 32'(idx), 32'(first + count));
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 20) begin
            step();
            n++;
        end
        chk({name, "_done"}, 32'(done), 32'd1);
        chk({name, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd1);
        chk({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic drain(input string name);
        wr_t e;
        wr_t o;
        step();
        chk({name, "_nwrites"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            chk({name, "_addr"}, 32'(o.addr), 32'(e.addr));
            chk({name, "_data"}, o.data, e.data);
            chk({name, "_latency"}, 32'(o.cyc), 32'(e.cyc));
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_wr_en"}, 32'(wr_en), 32'd0);
        chk({name, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_done"}, 32'(done), 32'd0);
        chk({name, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
        chk({name, "_wr_data"}, wr_data, 32'd0);
    endtask

    vec_t vecs [0:4];
    logic [63:0] fx;

    initial begin
        vecs[0] = '{2, 1'b1, 64'h2008_0005_2009_0007, 16'h0001, 1};
        vecs[1] = '{0, 1'b0, 64'h0, 16'h0001, 1};
        vecs[2] = '{1, 1'b0, 64'h0, 16'h0059, 7};
        vecs[3] = '{9, 1'b0, 64'h0, 16'h0001, 1};
        vecs[4] = '{3, 1'b0, 64'h0, 16'h0006, 4};

        // Reset state
        #13;
        chk_reset_outputs("reset");
        step();
        rst_n = 1'b1;
        step();
        chk("idle_in_ready", 32'(in_ready), 32'd0);
        chk("idle_cpu_rst_n", 32'(cpu_rst_n), 32'd0);

        // Vector table
        for (int v = 0; v < 5; v++) begin
            if (vecs[v].use_fixed) begin
                fx = vecs[v].fixed;
                for (int i = 0; i < 8; i++) stream[i] = fx[63 - 8*i -: 8];
            end else begin
                fill_random(4 * vecs[v].len);
            end
            do_start(vecs[v].len);
            if (vecs[v].len == 0) begin
                chk($sformatf("v%0d_zero_done", v), 32'(done), 32'd1);
                chk($sformatf("v%0d_zero_busy", v), 32'(busy), 32'd0);
                chk($sformatf("v%0d_zero_in_ready", v), 32'(in_ready), 32'd0);
            end else begin
                chk($sformatf("v%0d_busy", v), 32'(busy), 32'd1);
                chk($sformatf("v%0d_in_ready", v), 32'(in_ready), 32'd1);
                feed(0, 4 * vecs[v].len, vecs[v].vpat, vecs[v].vlen);
            end
            wait_done($sformatf("v%0d", v));
            drain($sformatf("v%0d", v));
        end

        // Abort after six bytes of a three-word load
        fill_random(12);
        do_start(3);
        feed(0, 6, 16'h0001, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        in_valid = 1'b1;
        step();
        step();
        chk("abort_stays_idle", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        drain("abort");

        // Start pulsed during LOAD must not disturb the running load
        fill_random(8);
        do_start(2);
        feed(0, 3, 16'h0001, 1);
        load_len = LW'(1);
        start    = 1'b1;
        step();
        start    = 1'b0;
        chk("restart_busy", 32'(busy), 32'd1);
        feed(3, 5, 16'h0001, 1);
        wait_done("restart");
        drain("restart");

        // Reset dropped while the 3rd byte of the second word is presented
        fill_random(8);
        do_start(2);
        feed(0, 6, 16'h0001, 1);
        in_valid = 1'b1;
        in_byte  = stream[6];
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        drain("midrst");
        fill_random(4);
        do_start(1);
        feed(0, 4, 16'h0001, 1);
        wait_done("postrst");
        drain("postrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
